// File: rtl/enemy_missile_launcher.sv
// Enemy missile launcher: waits a frame-tick delay, picks a living city,
// flies a missile toward it one pixel per frame, and reports impact or intercept.
module enemy_missile_launcher #(
    parameter logic [9:0]  START_X     = 10'd320,
    parameter logic [9:0]  TARGET_X0   = 10'd100,
    parameter logic [9:0]  TARGET_X1   = 10'd320,
    parameter logic [9:0]  TARGET_X2   = 10'd540,
    parameter logic [9:0]  GROUND_Y    = 10'd440,
    parameter int unsigned SPAWN_DELAY = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] target_sel,
    input  logic       frame_tick,
    input  logic [2:0] city_alive,
    input  logic       intercept,
    output logic [9:0] missile_x,
    output logic [9:0] missile_y,
    output logic       missile_active,
    output logic [1:0] target_idx,
    output logic       impact,
    output logic [1:0] impact_idx,
    output logic       intercepted
);

    localparam int unsigned CW = (SPAWN_DELAY < 2) ? 1 : $clog2(SPAWN_DELAY + 1);
    localparam logic [CW-1:0] DELAY_LD = CW'(SPAWN_DELAY);

    typedef enum logic [1:0] {IDLE, ARM, FLY, IMPACT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0]    x_n, y_n, y_inc, tgt_x;
    logic [1:0]    tidx_n, iidx_n;
    logic          intc_n;
    logic [1:0]    base, cand, pick;
    logic          pick_ok;

    // First living city at or after the requested index, wrapping 2 -> 0.
    always_comb begin
        base    = (target_sel > 3'd2) ? 2'd0 : target_sel[1:0];
        cand    = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = 2'((32'(base) + k) % 3);
            if (!pick_ok && city_alive[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        case (target_idx)
            2'd0:    tgt_x = TARGET_X0;
            2'd1:    tgt_x = TARGET_X1;
            default: tgt_x = TARGET_X2;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = missile_x;
        y_n     = missile_y;
        tidx_n  = target_idx;
        iidx_n  = impact_idx;
        intc_n  = 1'b0;
        y_inc   = missile_y + 10'd1;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    if (cnt == '0) state_n = ARM;
                    else           cnt_n   = cnt - CW'(1);
                end
            end
            ARM: begin
                if (pick_ok) begin
                    state_n = FLY;
                    x_n     = START_X;
                    y_n     = '0;
                    tidx_n  = pick;
                end else begin
                    state_n = IDLE;
                    cnt_n   = DELAY_LD;
                end
            end
            FLY: begin
                // Intercept takes precedence over a same-edge ground arrival.
                if (intercept) begin
                    state_n = IDLE;
                    cnt_n   = DELAY_LD;
                    intc_n  = 1'b1;
                end else if (frame_tick) begin
                    y_n = y_inc;
                    if (missile_x < tgt_x)      x_n = missile_x + 10'd1;
                    else if (missile_x > tgt_x) x_n = missile_x - 10'd1;
                    if (y_inc == GROUND_Y) begin
                        state_n = IMPACT;
                        iidx_n  = target_idx;
                    end
                end
            end
            IMPACT: begin
                state_n = IDLE;
                cnt_n   = DELAY_LD;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = DELAY_LD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= DELAY_LD;
            missile_x   <= START_X;
            missile_y   <= '0;
            target_idx  <= '0;
            impact_idx  <= '0;
            intercepted <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            missile_x   <= x_n;
            missile_y   <= y_n;
            target_idx  <= tidx_n;
            impact_idx  <= iidx_n;
            intercepted <= intc_n;
        end
    end

    assign missile_active = (state == FLY);
    assign impact         = (state == IMPACT);

endmodule

// File: tb/tb_enemy_missile_launcher.sv
// Directed plus randomized checks of enemy_missile_launcher against an
// arithmetic model of spawn delay, retargeting and flight position.
module tb_enemy_missile_launcher;

    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] target_sel = '0;
    logic       frame_tick = 1'b0;
    logic [2:0] city_alive = 3'b111;
    logic       intercept = 1'b0;
    logic [9:0] missile_x, missile_y;
    logic       missile_active;
    logic [1:0] target_idx;
    logic       impact;
    logic [1:0] impact_idx;
    logic       intercepted;

    int total = 0;
    int bad   = 0;
    int n_imp = 0;

    enemy_missile_launcher #(.SPAWN_DELAY(SD)) dut (
        .clk(clk), .rst(rst), .target_sel(target_sel), .frame_tick(frame_tick),
        .city_alive(city_alive), .intercept(intercept), .missile_x(missile_x),
        .missile_y(missile_y), .missile_active(missile_active), .target_idx(target_idx),
        .impact(impact), .impact_idx(impact_idx), .intercepted(intercepted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && impact) n_imp++;

    function automatic int exp_target(int sel, int alive);
        int b = (sel > 2) ? 0 : sel;
        for (int k = 0; k < 3; k++)
            if (((alive >> ((b + k) % 3)) & 1) == 1) return (b + k) % 3;
        return -1;
    endfunction

    function automatic int exp_x(int t, int n);
        int tx = (t == 0) ? 100 : (t == 1) ? 320 : 540;
        if (tx > 320) return (tx - 320 <= n) ? tx : 320 + n;
        if (tx < 320) return (320 - tx <= n) ? tx : 320 - n;
        return 320;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk); #1;
    endtask

    task automatic tick_edge();
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            tick_edge();
            repeat (3) clk1();
        end
    endtask

    task automatic chk_reset(string tag);
        check({tag, "_x"}, 32'(missile_x), 320);
        check({tag, "_y"}, 32'(missile_y), 0);
        check({tag, "_tidx"}, 32'(target_idx), 0);
        check({tag, "_iidx"}, 32'(impact_idx), 0);
        check({tag, "_act"}, 32'(missile_active), 0);
        check({tag, "_imp"}, 32'(impact), 0);
        check({tag, "_icp"}, 32'(intercepted), 0);
    endtask

    // Expects IDLE with a freshly loaded delay; returns the model's target (-1 = none).
    task automatic launch(int sel, int alive, string tag, output int t);
        target_sel = 3'(sel);
        city_alive = 3'(alive);
        ticks(SD);
        check({tag, "_early"}, 32'(missile_active), 0);
        ticks(1);
        target_sel = 3'($urandom);
        t = exp_target(sel, alive);
        if (t < 0) begin
            check({tag, "_nofly"}, 32'(missile_active), 0);
        end else begin
            check({tag, "_act"}, 32'(missile_active), 1);
            check({tag, "_tidx"}, 32'(target_idx), 32'(t));
            check({tag, "_x0"}, 32'(missile_x), 320);
            check({tag, "_y0"}, 32'(missile_y), 0);
        end
    endtask

    task automatic abort(string tag);
        intercept = 1'b1;
        clk1();
        intercept = 1'b0;
        check({tag, "_icp"}, 32'(intercepted), 1);
        check({tag, "_act"}, 32'(missile_active), 0);
        check({tag, "_imp"}, 32'(impact), 0);
        clk1();
        check({tag, "_icp_end"}, 32'(intercepted), 0);
    endtask

    initial begin
        int t;
        int n;
        int sel;
        int alive;
        logic [9:0] hx;
        logic [9:0] hy;

        repeat (2) clk1();
        chk_reset("reset");
        rst = 1'b0;

        launch(2, 7, "launch_t2", t);
        ticks(220);
        check("fly220_x", 32'(missile_x), 540);
        check("fly220_y", 32'(missile_y), 220);
        ticks(219);
        check("fly439_y", 32'(missile_y), 439);
        check("fly439_noimp", 32'(n_imp), 0);
        tick_edge();
        check("ground_imp", 32'(impact), 1);
        check("ground_iidx", 32'(impact_idx), 2);
        check("ground_act", 32'(missile_active), 0);
        check("ground_y", 32'(missile_y), 440);
        clk1();
        check("ground_imp_end", 32'(impact), 0);
        check("ground_icp", 32'(intercepted), 0);
        repeat (2) clk1();
        check("ground_pulses", 32'(n_imp), 1);

        launch(1, 5, "retarget_wrap", t);
        abort("abort_a");
        launch(5, 6, "retarget_hi", t);
        abort("abort_b");
        launch(0, 0, "no_city", t);
        launch(0, 7, "after_none", t);
        ticks(100);
        check("y100", 32'(missile_y), 100);
        abort("icp_y100");
        check("icp_y100_noimp", 32'(n_imp), 1);

        hx = missile_x;
        hy = missile_y;
        intercept = 1'b1;
        clk1();
        intercept = 1'b0;
        check("idle_icp", 32'(intercepted), 0);
        check("idle_icp_act", 32'(missile_active), 0);
        check("idle_icp_x", 32'(missile_x), 32'(hx));
        check("idle_icp_y", 32'(missile_y), 32'(hy));
        clk1();

        launch(0, 7, "race", t);
        ticks(439);
        check("race_x", 32'(missile_x), 32'(exp_x(0, 439)));
        check("race_y", 32'(missile_y), 439);
        intercept = 1'b1;
        tick_edge();
        intercept = 1'b0;
        check("race_icp", 32'(intercepted), 1);
        check("race_imp", 32'(impact), 0);
        clk1();
        check("race_imp_late", 32'(impact), 0);
        repeat (3) clk1();
        check("race_pulses", 32'(n_imp), 1);

        launch(1, 7, "midrst", t);
        ticks(200);
        check("midrst_y", 32'(missile_y), 200);
        rst = 1'b1;
        intercept = 1'b1;
        frame_tick = 1'b1;
        clk1();
        rst = 1'b0;
        intercept = 1'b0;
        frame_tick = 1'b0;
        chk_reset("midrst_state");
        launch(2, 7, "post_rst", t);
        abort("post_rst_abort");

        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 7));
            alive = int'($urandom_range(0, 7));
            launch(sel, alive, "rnd_launch", t);
            if (t >= 0) begin
                n = int'($urandom_range(1, 300));
                city_alive = 3'($urandom);
                ticks(n);
                check("rnd_x", 32'(missile_x), 32'(exp_x(t, n)));
                check("rnd_y", 32'(missile_y), 32'(n));
                check("rnd_tidx", 32'(target_idx), 32'(t));
                abort("rnd_abort");
            end
        end
        check("final_pulses", 32'(n_imp), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enemy_missile_launcher.md
ENEMY_MISSILE_LAUNCHER -- requirements
Module: enemy_missile_launcher

Interface
REQ-001 Parameter START_X, default 320: missile spawn column (10-bit).
REQ-002 Parameter TARGET_X0 / TARGET_X1 / TARGET_X2, defaults 100 / 320 / 540: city columns for indices 0 / 1 / 2.
REQ-003 Parameter GROUND_Y, default 440: impact row.
REQ-004 Parameter SPAWN_DELAY, default 60: frame ticks between missiles.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 target_sel  in  3  target index from the targeting shift register; valid 0..2.
REQ-008 frame_tick  in  1  one-clk-wide pulse, once per video frame.
REQ-009 city_alive  in  3  bit i = 1 when city i still stands.
REQ-010 intercept  in  1  one-clk pulse; player explosion has hit this missile.
REQ-011 missile_x, missile_y  out  10 each  current missile position.
REQ-012 missile_active  out  1  high in FLY only.
REQ-013 target_idx  out  2  latched city index for the current flight.
REQ-014 impact  out  1  one-clk pulse when the missile reaches GROUND_Y.
REQ-015 impact_idx  out  2  city hit; valid while impact = 1.
REQ-016 intercepted  out  1  one-clk pulse when a flying missile is destroyed.

Function
REQ-017 FSM states: IDLE, ARM, FLY, IMPACT; 2-bit encoding.
REQ-018 IDLE: delay counter (width of SPAWN_DELAY) is loaded with SPAWN_DELAY on entry; on each frame_tick, if counter = 0 go to ARM, else decrement; clk cycles without frame_tick change nothing.
REQ-019 ARM (exactly one clk): sample target_sel; values 3..7 are treated as 0.
REQ-020 Retarget in ARM: if the sampled city is dead, pick the next alive index ascending with wrap 2->0.
REQ-021 If city_alive = 000 in ARM, return to IDLE with the counter reloaded; no flight starts.
REQ-022 ARM exit to FLY: missile_x = START_X, missile_y = 0, target_idx = chosen index, missile_active = 1.
REQ-023 FLY, per frame_tick: missile_y += 1; missile_x steps 1 toward TARGET_X[target_idx] (+1 if less, -1 if greater, hold if equal); no clipping or wrap needed because y never exceeds GROUND_Y.
REQ-024 FLY: when the updated missile_y equals GROUND_Y, next state is IMPACT.
REQ-025 IMPACT (exactly one clk): impact = 1, impact_idx = target_idx, missile_active = 0; then go to IDLE.
REQ-026 intercept in FLY: go to IDLE on the next edge; intercepted = 1 for one clk; missile_active = 0; no impact.
REQ-027 intercept outside FLY is ignored; intercepted stays 0.
REQ-028 intercept and ground arrival on the same edge: intercept wins; no impact pulse.
REQ-029 city_alive changes during FLY do not alter target_idx.
REQ-030 target_sel is read only in ARM; it is a don't-care in every other state.
REQ-031 impact and intercepted are never high in the same cycle, and each lasts exactly one clk.

Reset
REQ-032 rst = 1 at any clk edge, including mid-flight, forces the following state:
  - state IDLE, counter = SPAWN_DELAY
  - missile_x = START_X, missile_y = 0, target_idx = 0, impact_idx = 0
  - missile_active = 0, impact = 0, intercepted = 0
REQ-033 rst has priority over every other input, including intercept and frame_tick in the same cycle.
REQ-034 After rst deasserts, the first launch requires SPAWN_DELAY+1 frame_ticks.

Verification
REQ-035 SPAWN_DELAY = 2, city_alive = 111, target_sel = 2, tick every 4 clks -> ARM after the 3rd tick; FLY with target_idx = 2, x = 320, y = 0.
REQ-036 Flight to target 2 with default params -> after 220 ticks x = 540, y = 220; after 440 ticks y = 440, then one impact pulse with impact_idx = 2, then IDLE.
REQ-037 target_sel = 1, city_alive = 101 -> target_idx = 2; target_sel = 5, city_alive = 110 -> target_idx = 1; city_alive = 000 -> no FLY, IDLE with counter reloaded.
REQ-038 intercept at y = 100 -> intercepted pulses once, missile_active = 0, no impact; intercept asserted in IDLE -> no output change.
REQ-039 intercept on the same edge as y reaching 440 -> intercepted = 1, impact = 0.
REQ-040 rst at y = 200 -> next cycle: outputs match REQ-032, then a fresh SPAWN_DELAY+1 tick wait before the next launch.
